// File: rtl/snake_pkg.sv
// Shared constants and width helpers for the snake body shift register.
// Holds the default geometry, the index/length width functions and the x/y split of a position code.
package snake_pkg;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_DEPTH = 32;

    // Packed position code: y in the upper bits, x in the lower bits.
    localparam int POS_X_BITS = 3;
    localparam int POS_Y_BITS = DEF_WIDTH - POS_X_BITS;
    localparam int POS_X_LSB  = 0;
    localparam int POS_X_MSB  = POS_X_LSB + POS_X_BITS - 1;
    localparam int POS_Y_LSB  = POS_X_MSB + 1;
    localparam int POS_Y_MSB  = POS_Y_LSB + POS_Y_BITS - 1;

    typedef struct packed {
        logic [POS_Y_BITS-1:0] y;
        logic [POS_X_BITS-1:0] x;
    } pos_t;

    // Width of an index that addresses depth entries.
    function automatic int idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Width of a count that spans 0..depth.
    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/body_cell.sv
// One body segment register: load-enabled WIDTH-bit flop with synchronous reset to INIT.
// Generalises the original fixed 6-bit init/reset register; one instance per body entry.
module body_cell #(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] val_q;

    always_comb begin
        val_d = val_q;
        if (load) val_d = din;
    end

    // NOTE: state registers use non-blocking assignments so every cell samples its
    // neighbour's pre-edge value; blocking here would collapse the shift chain.
    always_ff @(posedge clk) begin
        if (reset) val_q <= INIT;
        else       val_q <= val_d;
    end

    assign dout = val_q;

endmodule

// File: rtl/snake_body_shift_reg.sv
// Snake body: DEPTH-entry shift chain (head at entry 0) with live length, deferred growth and a registered read port.
// Optional self-collision detection is built when SNAKE_BODY_SELF_HIT_EN is defined; otherwise hit is tied low.
module snake_body_shift_reg
    import snake_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               DEPTH      = DEF_DEPTH,
    parameter int               INIT_LEN   = 3,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter int               MAX_PEND   = 7,
    localparam int              IDXW       = idx_w(DEPTH),
    localparam int              LENW       = len_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] head_in,
    input  logic             grow,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail,
    output logic [LENW-1:0]  length,
    output logic             full,
    output logic             hit
);

    localparam int              PENDW     = $clog2(MAX_PEND + 1);
    localparam logic [PENDW-1:0] PEND_MAX = PENDW'(MAX_PEND);
    localparam logic [LENW-1:0]  LEN_INIT = LENW'(INIT_LEN);
    localparam logic [LENW-1:0]  LEN_MAX  = LENW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] ent;

    logic [LENW-1:0]  len_d,  len_q;
    logic [PENDW-1:0] pend_d, pend_q;
    logic [WIDTH-1:0] rd_d,   rd_q;
    logic             grow_take;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [WIDTH-1:0] cell_din;
        if (i == 0) begin : g_head
            assign cell_din = head_in;
        end else begin : g_body
            assign cell_din = ent[i-1];
        end

        body_cell #(
            .WIDTH (WIDTH),
            .INIT  (INIT_VALUE)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (advance),
            .din   (cell_din),
            .dout  (ent[i])
        );
    end

    assign full      = (len_q == LEN_MAX);
    assign grow_take = advance && !full && ((pend_q != '0) || grow);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        len_d  = len_q;
        pend_d = pend_q;
        if (advance) begin
            if (full) begin
                pend_d = '0;
            end else if (grow_take) begin
                len_d = len_q + LENW'(1);
                // A fresh request in the same cycle replaces the one consumed.
                if (!grow) pend_d = pend_q - PENDW'(1);
            end
        end else if (grow && (pend_q != PEND_MAX)) begin
            pend_d = pend_q + PENDW'(1);
        end
    end

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDXW'(i)) rd_d = ent[i];
        end
    end

    always_comb begin
        tail = ent[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (len_q == LENW'(i + 1)) tail = ent[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= LEN_INIT;
            pend_q <= '0;
            rd_q   <= INIT_VALUE;
        end else begin
            len_q  <= len_d;
            pend_q <= pend_d;
            rd_q   <= rd_d;
        end
    end

`ifdef SNAKE_BODY_SELF_HIT_EN
    logic hit_d, hit_q;

    // The tail vacates on this tick unless growth keeps it, so it only counts when growing.
    always_comb begin
        hit_d = hit_q;
        if (advance) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (((i + 1 < int'(len_q)) || (grow_take && (i + 1 == int'(len_q))))
                    && (ent[i] == head_in)) begin
                    hit_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hit_q <= 1'b0;
        else       hit_q <= hit_d;
    end

    assign hit = hit_q;
`else
    assign hit = 1'b0;
`endif

    assign head    = ent[0];
    assign length  = len_q;
    assign rd_data = rd_q;

endmodule

// File: doc/snake_body_shift_reg.md
Name: snake_body_shift_reg

Overview:
Parametrised, enable-gated successor to the fixed 6-bit init/reset register: a DEPTH-entry chain of WIDTH-bit position registers holding the snake body, head at entry 0.
- Shifts one place per game tick, with programmable initial contents.
- Tracks live length, with deferred growth requests applied on later ticks.
- Provides a random-access read port for the VGA renderer.
- Sits between the movement controller (supplies new head position each tick) and the renderer/collision logic.

Parameters:
WIDTH, 6, bits per entry (packed position code)
DEPTH, 32, number of body entries (max snake length), >= 2
INIT_LEN, 3, live length after reset, 1..DEPTH
INIT_VALUE, 6'b0, value loaded into every entry on reset
MAX_PEND, 7, saturation limit of the pending-growth counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
advance  input  1  game tick: shift body, load head_in into entry 0
head_in  input  WIDTH  new head position, sampled when advance=1
grow  input  1  one-cycle request: add one segment on a future advance
rd_idx  input  IDXW=$clog2(DEPTH)  renderer read index
rd_data  output  WIDTH  entry[rd_idx], registered (1-cycle latency)
head  output  WIDTH  entry[0], combinational from registers
tail  output  WIDTH  entry[length-1], combinational from registers
length  output  LENW=$clog2(DEPTH+1)  live segment count
full  output  1  length == DEPTH
hit  output  1  self-collision flag (see Optional Feature)

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset (has priority over all inputs in the same cycle):
  - all entries = INIT_VALUE
  - length = INIT_LEN, pend = 0
  - rd_data = INIT_VALUE, hit = 0
- advance=1:
  - entry[0] <= head_in
  - entry[i] <= entry[i-1] for i=1..DEPTH-1; entry[DEPTH-1]'s old value is discarded
  - Entries at or beyond length also shift; they are don't-care for consumers but deterministic.
- Growth:
  - pend counter: +1 on grow, saturating at MAX_PEND.
  - On advance with pend>0 (or grow in the same cycle) and !full: length +1.
  - The consumed request decrements pend. If a new grow arrives in the same cycle, the two cancel: pend is unchanged.
  - When full: length holds, and pend is cleared to 0 on that advance.
  - grow without advance: pend only; length unchanged.
- length never exceeds DEPTH and never drops below INIT_LEN (this block has no shrink).
- tail/head/full/length reflect register state; they update the cycle after an advance.
- rd_data:
  - registered entry[rd_idx], 1-cycle latency
  - rd_idx >= DEPTH returns 0
  - reads are valid regardless of length; masking by length is the renderer's job
- Simultaneous advance+read: rd_data returns the pre-shift value of entry[rd_idx].
- reset asserted mid-sequence: all state restored in that cycle; pend is lost.

Optional Feature:
SNAKE_BODY_SELF_HIT_EN
- Defined: hit is registered. It is set on an advance cycle if head_in equals entry[i] for any i in 1..length-2. The tail (entry[length-1]) is excluded because it vacates on the same tick, unless growth is applied that tick, in which case the tail is included. hit is sticky until reset.
- Undefined: hit tied to 0 and no comparators are built.

Decomposition:
- Shared package snake_pkg:
  - default WIDTH/DEPTH constants
  - IDXW/LENW helper function (clog2)
  - position field split constants (x/y bit ranges within WIDTH)
- Sub-module body_cell: a WIDTH-parametrised register with INIT parameter, synchronous reset to INIT, and load enable. It is the generalisation of the single init/reset register; one instance is generated per entry.

Test Plan:
1. Reset with INIT_LEN=3, INIT_VALUE=6'h05 -> length=3, head=tail=6'h05, full=0, hit=0, rd_data=6'h05 after 1 cycle.
2. Advance with head_in=6'h11, 6'h12, 6'h13, no grow -> head=6'h13, entry1=6'h12, tail=entry2=6'h11, length stays 3.
3. Pulse grow twice, then 3 advances -> length 3→4→5→5; pend 2→1→0.
4. DEPTH=4, INIT_LEN=3, grow+advance x3 -> length saturates at 4, full=1, pend=0 after the full-state advance.
5. grow, advance and reset in the same cycle -> reset wins: length=INIT_LEN, pend=0, entries=INIT_VALUE.
6. SNAKE_BODY_SELF_HIT_EN defined, length=5, entries 6'h10..6'h14, advance with head_in=6'h12 -> hit=1 next cycle and held. With head_in equal to the tail and no growth -> hit stays 0.
